cpu_ram_arbiter: RTL and testbench
==================================

# cpu_ram_arbiter

Shares the single video/main RAM port between the Z80 core and the video fetcher. It generates the CPU's `cep`/`cen` clock enables and grants the video fetcher fixed-priority RAM slots. While the video fetcher owns RAM, it stretches the current CPU T-state by freezing those enables. It sits between the CPU wrapper, the video generator and the RAM controller.

## Interface
- `DIV`, 8, system clocks per CPU T-state. Must be even and ≥ 4.
- `VLEN`, 2, system clocks per video RAM slot. Must be ≥ 1.
- `MINCPU`, 4, minimum unfrozen divider clocks between two consecutive video slots. This is the starvation guard.
- `clock` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `mreq` in 1: CPU MREQ_n, active-low.
- `wr` in 1: CPU WR_n, active-low.
- `a` in 16: CPU address.
- `vreq` in 1: video fetch request. Level; held high until `vack`.
- `vaddr` in 16: video fetch address, stable while `vreq` is high.
- `cep` out 1: CPU positive-phase clock enable, one-clock pulse.
- `cen` out 1: CPU negative-phase clock enable, one-clock pulse.
- `vack` out 1: one-clock pulse; RAM data for `vaddr` is valid on this cycle.
- `ram_a` out 16: registered RAM address.
- `ram_we` out 1: registered RAM write enable, active-high.
- `stall` out 1: high while the divider is frozen by a video slot.

## Operation
- Divider `cnt` counts 0..DIV-1 and wraps.
  - `cep` = 1 on the clock where `cnt`==DIV-1 and the divider is not frozen.
  - `cen` = 1 on the clock where `cnt`==DIV/2-1 and the divider is not frozen.
- State machine has two states:
  - CPU: `ram_a`<=`a`; `ram_we`<=(`mreq`==0 && `wr`==0). Divider runs. `guard` counts up, saturating at MINCPU.
  - VID: `ram_a`<=`vaddr`; `ram_we`<=0. Divider is frozen (`cnt` holds, no `cep`/`cen`). `vcnt` counts 0..VLEN-1.
- CPU→VID when `vreq`==1 and `guard`==MINCPU. The transition takes effect on the next edge; `guard` clears to 0.
- VID→CPU when `vcnt`==VLEN-1. `vack`=1 on the first CPU-state clock after the slot, i.e. one clock after the last VID clock (RAM read latency 1).
- Video has priority over an active CPU memory cycle. The CPU sees only a longer T-state, because its strobes and data stay stable while enables are frozen. A CPU write is therefore never split: `ram_we` drops during VID and reasserts with identical `ram_a` afterwards.
- `vreq` dropping before grant: no slot, no `vack`.
- `vreq` still high on the `vack` cycle: treated as a new request, subject to the `guard` rule.
- A `vreq` edge coinciding with `cnt` wrap: the VID grant wins. `cep` for that wrap is deferred until the divider resumes, not lost.
- Reset mid-slot: immediate return to reset state; no `vack` is issued.

## Timing
- Reset values:
  - `cnt`=0, `vcnt`=0, `guard`=MINCPU, state=CPU.
  - `cep`=0, `cen`=0, `vack`=0, `stall`=0.
  - `ram_a`=0, `ram_we`=0.
- After reset release, the first `cen` occurs at clock DIV/2 and the first `cep` at clock DIV.
- Unstalled `cep` period is exactly DIV clocks; `cen` is DIV/2 clocks after the preceding `cep`.
- `vreq` high to first VID clock: 1 clock (guard satisfied).
- `vreq` high to `vack`: VLEN+1 clocks.
- Each video slot delays every later `cep`/`cen` by exactly VLEN clocks.
- Worst-case CPU share under continuous `vreq`: MINCPU/(MINCPU+VLEN) of clocks.
- `ram_a`/`ram_we` lag CPU inputs by 1 clock.
- `stall` equals (state==VID), registered.

## Structure
- Shared package `lynx_pkg`:
  - state enum `ARB_CPU`/`ARB_VID`;
  - default constants for DIV, VLEN, MINCPU.
- One natural sub-module, `ce_divider`: the freezable counter producing `cep`/`cen`, with a `hold` input.
- Arbitration FSM, `guard`/`vcnt` counters and RAM port registers live in the top module.

## Test plan
- Reset, no `vreq`, DIV=8:
  - first `cen` at clock 4, first `cep` at clock 8, then `cep` every 8 clocks;
  - all outputs 0 during reset.
- Single `vreq` at `cnt`==2, `vaddr`=16'h4000:
  - `ram_a`=16'h4000 for 2 clocks, `stall`=1 for 2 clocks;
  - `vack` pulses at +3;
  - next `cep` arrives 10 clocks after the previous one.
- CPU write (`mreq`=0, `wr`=0, `a`=16'h1234) with `vreq` asserted mid-cycle:
  - `ram_we` goes 1→0 for VLEN clocks, then back to 1;
  - `ram_a` returns to 16'h1234;
  - no `cep` during the slot.
- `vreq` held high continuously: VID slots separated by exactly MINCPU CPU-state clocks, and `cep` still advances.
- `vreq` pulsed high for 1 clock while `guard`<MINCPU: no grant, no `vack`.
- Reset asserted during the VID slot: outputs clear asynchronously; after release, timing matches the first scenario and no `vack` is issued.

Source files
------------

// File: rtl/lynx_pkg.sv
// Shared types and default timing for the Lynx CPU/video RAM arbitration.
package lynx_pkg;

  typedef enum logic {
    ARB_CPU = 1'b0,
    ARB_VID = 1'b1
  } arb_state_t;

  localparam int LYNX_DIV    = 8;
  localparam int LYNX_VLEN   = 2;
  localparam int LYNX_MINCPU = 4;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ce_divider.sv
// Freezable T-state divider producing the Z80 cep/cen clock enables.
module ce_divider
  import lynx_pkg::*;
#(
  parameter int DIV = LYNX_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic hold,
  output logic cep,
  output logic cen
);

  localparam int CW = cnt_width(DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!hold) begin
      cnt_d = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A frozen divider suppresses the enable, so a pending edge waits out the slot.
  assign cep = !hold && (cnt_q == CW'(DIV - 1));
  assign cen = !hold && (cnt_q == CW'(DIV / 2 - 1));

endmodule

// File: rtl/cpu_ram_arbiter.sv
// Shares the RAM port between the Z80 and the video fetcher; video slots
// freeze the CPU clock enables so the CPU only sees a longer T-state.
//
// state   | meaning
// ARB_CPU | CPU drives RAM, divider runs, guard refills toward MINCPU
// ARB_VID | video slot of VLEN clocks, divider frozen, RAM writes blocked
module cpu_ram_arbiter
  import lynx_pkg::*;
#(
  parameter int DIV    = LYNX_DIV,
  parameter int VLEN   = LYNX_VLEN,
  parameter int MINCPU = LYNX_MINCPU
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mreq,
  input  logic        wr,
  input  logic [15:0] a,
  input  logic        vreq,
  input  logic [15:0] vaddr,
  output logic        cep,
  output logic        cen,
  output logic        vack,
  output logic [15:0] ram_a,
  output logic        ram_we,
  output logic        stall
);

  localparam int VW = cnt_width(VLEN);
  localparam int GW = cnt_width(MINCPU + 1);

  arb_state_t    state_q, state_d;
  logic [GW-1:0] guard_q, guard_d, guard_inc;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          vack_q, vack_d;
  logic [15:0]   ram_a_q, ram_a_d;
  logic          ram_we_q, ram_we_d;

  ce_divider #(.DIV(DIV)) u_div (
    .clock (clock),
    .reset (reset),
    .hold  (state_q == ARB_VID),
    .cep   (cep),
    .cen   (cen)
  );

  always_comb begin
    state_d   = state_q;
    guard_d   = guard_q;
    vcnt_d    = vcnt_q;
    vack_d    = 1'b0;
    // guard counts the current CPU clock too, so MINCPU CPU clocks separate slots
    guard_inc = (guard_q == GW'(MINCPU)) ? guard_q : guard_q + GW'(1);
    unique case (state_q)
      ARB_CPU: begin
        if (vreq && (guard_inc == GW'(MINCPU))) begin
          state_d = ARB_VID;
          guard_d = '0;
          vcnt_d  = '0;
        end else begin
          guard_d = guard_inc;
        end
      end
      ARB_VID: begin
        if (vcnt_q == VW'(VLEN - 1)) begin
          state_d = ARB_CPU;
          vcnt_d  = '0;
          vack_d  = 1'b1;
        end else begin
          vcnt_d = vcnt_q + VW'(1);
        end
      end
    endcase
    ram_a_d  = (state_d == ARB_VID) ? vaddr : a;
    ram_we_d = (state_d == ARB_CPU) && !mreq && !wr;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_CPU;
      guard_q  <= GW'(MINCPU);
      vcnt_q   <= '0;
      vack_q   <= 1'b0;
      ram_a_q  <= '0;
      ram_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      guard_q  <= guard_d;
      vcnt_q   <= vcnt_d;
      vack_q   <= vack_d;
      ram_a_q  <= ram_a_d;
      ram_we_q <= ram_we_d;
    end
  end

  assign vack   = vack_q;
  assign ram_a  = ram_a_q;
  assign ram_we = ram_we_q;
  assign stall  = (state_q == ARB_VID);

endmodule

// File: tb/tb_cpu_ram_arbiter.sv
// Self-checking bench for cpu_ram_arbiter; enable/ack timing via event queues.
module tb_cpu_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mreq  = 1'b1;
  logic        wr    = 1'b1;
  logic [15:0] a     = 16'h0000;
  logic        vreq  = 1'b0;
  logic [15:0] vaddr = 16'h0000;
  logic        cep, cen, vack, ram_we, stall;
  logic [15:0] ram_a;

  int checks = 0;
  int errors = 0;
  int clk_no = 0;
  int exp_cep[$];
  int exp_cen[$];
  int exp_vack[$];
  bit trk_ce   = 1'b0;
  bit trk_vack = 1'b0;
  int mon_e;

  cpu_ram_arbiter #(.DIV(8), .VLEN(2), .MINCPU(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .mreq   (mreq),
    .wr     (wr),
    .a      (a),
    .vreq   (vreq),
    .vaddr  (vaddr),
    .cep    (cep),
    .cen    (cen),
    .vack   (vack),
    .ram_a  (ram_a),
    .ram_we (ram_we),
    .stall  (stall)
  );

  always #5 clock = ~clock;

  // tick = clock number since reset release; tick 1 is the cycle with cnt==0
  always @(posedge clock) begin
    if (!reset) clk_no = 0;
    else        clk_no = clk_no + 1;
  end

  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (trk_ce && cep) begin
        checks++;
        if (exp_cep.size() == 0) begin
          errors++;
          $display("FAIL cep_time: cep at tick %0d, none expected", clk_no + 1);
        end else begin
          mon_e = exp_cep.pop_front();
          if (mon_e != clk_no + 1) begin
            errors++;
            $display("FAIL cep_time: cep at tick %0d, expected tick %0d", clk_no + 1, mon_e);
          end
        end
      end
      if (trk_ce && cen) begin
        checks++;
        if (exp_cen.size() == 0) begin
          errors++;
          $display("FAIL cen_time: cen at tick %0d, none expected", clk_no + 1);
        end else begin
          mon_e = exp_cen.pop_front();
          if (mon_e != clk_no + 1) begin
            errors++;
            $display("FAIL cen_time: cen at tick %0d, expected tick %0d", clk_no + 1, mon_e);
          end
        end
      end
      if (trk_vack && vack) begin
        checks++;
        if (exp_vack.size() == 0) begin
          errors++;
          $display("FAIL vack_time: vack at tick %0d, none expected", clk_no + 1);
        end else begin
          mon_e = exp_vack.pop_front();
          if (mon_e != clk_no + 1) begin
            errors++;
            $display("FAIL vack_time: vack at tick %0d, expected tick %0d", clk_no + 1, mon_e);
          end
        end
      end
    end
  end

  task automatic run_to(input int n);
    int budget = 0;
    while ((clk_no + 1 != n) && (budget < 500)) begin
      @(negedge clock);
      budget++;
    end
    if (clk_no + 1 != n) begin
      errors++;
      $display("FAIL run_to: at tick %0d, wanted tick %0d", clk_no + 1, n);
    end
  endtask

  task automatic do_reset();
    trk_ce   = 1'b0;
    trk_vack = 1'b0;
    exp_cep.delete();
    exp_cen.delete();
    exp_vack.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    a = 16'hFFFF; mreq = 1'b0; wr = 1'b0; vreq = 1'b1; vaddr = 16'hBEEF;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({cep, cen} !== 2'b00) begin
      errors++; $display("FAIL reset_ce: cep/cen %b, expected 00", {cep, cen});
    end
    checks++;
    if ({vack, stall} !== 2'b00) begin
      errors++; $display("FAIL reset_vack_stall: %b, expected 00", {vack, stall});
    end
    checks++;
    if (ram_a !== 16'h0000 || ram_we !== 1'b0) begin
      errors++; $display("FAIL reset_ram: ram_a %h ram_we %b, expected 0000 0", ram_a, ram_we);
    end
    a = 16'h0000; mreq = 1'b1; wr = 1'b1; vreq = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    exp_cen = '{4, 12, 20};
    exp_cep = '{8, 16, 24};
    trk_ce = 1'b1; trk_vack = 1'b1;
    run_to(26);
    #1;
    checks++;
    if (exp_cep.size() + exp_cen.size() != 0) begin
      errors++; $display("FAIL reset_ce_missing: %0d enables pending, expected 0", exp_cep.size() + exp_cen.size());
    end
  endtask

  task automatic test_single_vreq();
    logic        e_stall;
    logic [15:0] e_ra;
    a = 16'h00AA; vaddr = 16'h4000; mreq = 1'b1; wr = 1'b1; vreq = 1'b0;
    do_reset();
    exp_cen = '{4, 14}; exp_cep = '{8, 18}; exp_vack = '{14};
    trk_ce = 1'b1; trk_vack = 1'b1;
    for (int t = 11; t <= 16; t++) begin
      run_to(t);
      if (t == 11) vreq = 1'b1;
      if (t == 14) vreq = 1'b0;
      e_stall = (t == 12 || t == 13);
      e_ra    = e_stall ? 16'h4000 : 16'h00AA;
      checks++;
      if (stall !== e_stall || ram_a !== e_ra) begin
        errors++;
        $display("FAIL single_slot t%0d: stall %b ram_a %h, expected %b %h", t, stall, ram_a, e_stall, e_ra);
      end
    end
    run_to(20);
    #1;
    checks++;
    if (exp_cep.size() + exp_cen.size() + exp_vack.size() != 0) begin
      errors++; $display("FAIL single_missing: %0d events pending, expected 0", exp_cep.size() + exp_cen.size() + exp_vack.size());
    end
  endtask

  task automatic test_cpu_write();
    logic        e_we;
    logic [15:0] e_ra;
    a = 16'h1234; mreq = 1'b0; wr = 1'b0; vaddr = 16'h5555; vreq = 1'b0;
    do_reset();
    exp_cen = '{4, 14}; exp_cep = '{10, 18}; exp_vack = '{8};
    trk_ce = 1'b1; trk_vack = 1'b1;
    for (int t = 2; t <= 9; t++) begin
      run_to(t);
      if (t == 5) vreq = 1'b1;
      if (t == 8) vreq = 1'b0;
      e_we = !(t == 6 || t == 7);
      e_ra = e_we ? 16'h1234 : 16'h5555;
      checks++;
      if (ram_we !== e_we || ram_a !== e_ra) begin
        errors++;
        $display("FAIL cpu_write t%0d: ram_we %b ram_a %h, expected %b %h", t, ram_we, ram_a, e_we, e_ra);
      end
    end
    run_to(20);
    #1;
    checks++;
    if (exp_cep.size() + exp_cen.size() + exp_vack.size() != 0) begin
      errors++; $display("FAIL write_missing: %0d events pending, expected 0", exp_cep.size() + exp_cen.size() + exp_vack.size());
    end
    mreq = 1'b1; wr = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic e_stall;
    vreq = 1'b1; a = 16'h0000; vaddr = 16'h4100; mreq = 1'b1; wr = 1'b1;
    do_reset();
    exp_cep  = '{12, 24};
    exp_cen  = '{6, 18, 30};
    exp_vack = '{4, 10, 16, 22, 28};
    trk_ce = 1'b1; trk_vack = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      run_to(t);
      e_stall = (t >= 2) && (((t - 2) % 6) < 2);
      checks++;
      if (stall !== e_stall) begin
        errors++; $display("FAIL b2b_stall t%0d: stall %b, expected %b", t, stall, e_stall);
      end
    end
    run_to(31);
    #1;
    checks++;
    if (exp_cep.size() + exp_cen.size() + exp_vack.size() != 0) begin
      errors++; $display("FAIL b2b_missing: %0d events pending, expected 0", exp_cep.size() + exp_cen.size() + exp_vack.size());
    end
    vreq = 1'b0;
  endtask

  task automatic test_short_pulse();
    logic e_stall;
    vaddr = 16'h6000; vreq = 1'b0;
    do_reset();
    exp_vack = '{6};
    trk_vack = 1'b1;
    for (int t = 3; t <= 14; t++) begin
      run_to(t);
      if (t == 3) vreq = 1'b1;
      if (t == 6) vreq = 1'b0;
      if (t == 7) vreq = 1'b1;
      if (t == 8) vreq = 1'b0;
      e_stall = (t == 4 || t == 5);
      checks++;
      if (stall !== e_stall) begin
        errors++; $display("FAIL pulse_stall t%0d: stall %b, expected %b", t, stall, e_stall);
      end
    end
    run_to(16);
    #1;
    checks++;
    if (exp_vack.size() != 0) begin
      errors++; $display("FAIL pulse_missing: %0d vack pending, expected 0", exp_vack.size());
    end
  endtask

  task automatic test_reset_mid_slot();
    a = 16'h0077; vaddr = 16'h4000; vreq = 1'b0; mreq = 1'b1; wr = 1'b1;
    do_reset();
    trk_vack = 1'b1;
    run_to(3);
    vreq = 1'b1;
    run_to(4);
    checks++;
    if (stall !== 1'b1 || ram_a !== 16'h4000) begin
      errors++; $display("FAIL mid_slot_start: stall %b ram_a %h, expected 1 4000", stall, ram_a);
    end
    reset = 1'b0;
    vreq  = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || ram_a !== 16'h0000 || vack !== 1'b0) begin
      errors++; $display("FAIL mid_slot_clear: stall %b ram_a %h vack %b, expected 0 0000 0", stall, ram_a, vack);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    exp_cen = '{4, 12}; exp_cep = '{8, 16};
    trk_ce = 1'b1; trk_vack = 1'b1;
    run_to(18);
    #1;
    checks++;
    if (exp_cep.size() + exp_cen.size() + exp_vack.size() != 0) begin
      errors++; $display("FAIL mid_slot_missing: %0d events pending, expected 0", exp_cep.size() + exp_cen.size() + exp_vack.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_vreq();
    test_cpu_write();
    test_back_to_back();
    test_short_pulse();
    test_reset_mid_slot();
    trk_ce = 1'b0; trk_vack = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
